// File: rtl/booth_mult_arbiter.sv
// -----------------------------------------------------------------------------
// booth_mult_arbiter
//
// Round-robin scheduler that lets NREQ client blocks share one external
// booth_radix8_multiplier. Requests are accepted over valid/ready, issued
// to the multiplier one at a time, and the product is returned tagged with
// the requester index. Only one operation is outstanding at any time.
//
// Optional feature macro: BOOTH_ARB_TIMEOUT_EN
//   Defined   : a watchdog counts WAIT cycles. After TIMEOUT_CYCLES cycles
//               without a qualifying mul_done, a response is produced with
//               rsp_product=0 and rsp_error=1.
//   Undefined : WAIT waits indefinitely and rsp_error is constant 0.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-high
//   req_valid    in   [NREQ]        per-requester request valid
//   req_ready    out  [NREQ]        one-hot accept strobe (combinational)
//   req_a        in   [NREQ*WIDTH]  multiplicands, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   [NREQ*WIDTH]  multipliers, same packing
//   req_mode     in   [NREQ*2]      sign mode ([1]=A signed, [0]=B signed)
//   rsp_valid    out                response valid
//   rsp_ready    in                 response consumer ready
//   rsp_id       out  [IDW]         requester index of the response
//   rsp_product  out  [2*WIDTH]     product
//   rsp_error    out                watchdog timeout flag
//   mul_start    out                one-cycle start pulse to the multiplier
//   mul_a        out  [WIDTH]       multiplicand to the multiplier
//   mul_b        out  [WIDTH]       multiplier operand to the multiplier
//   mul_mode     out  [2]           sign mode to the multiplier
//   mul_product  in   [2*WIDTH]     product from the multiplier
//   mul_done     in                 completion strobe from the multiplier
//   mul_busy     in                 multiplier busy
// -----------------------------------------------------------------------------
module booth_mult_arbiter #(
  parameter int WIDTH          = 16,
  parameter int NREQ           = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*2-1:0]       req_mode,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    rsp_error,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic [1:0]              mul_mode,
  input  logic [2*WIDTH-1:0]      mul_product,
  input  logic                    mul_done,
  input  logic                    mul_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time parameter sanity checks.
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
    $error("booth_mult_arbiter: NREQ must be in 2..8");
  end
  if ((1 << IDW) < NREQ) begin : g_idw_check
    $error("booth_mult_arbiter: IDW too narrow for NREQ");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("booth_mult_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic            wait_first_reg;

  // ---------------------------------------------------------------------------
  // Per-requester operand views
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op_a    [NREQ];
  logic [WIDTH-1:0] op_b    [NREQ];
  logic [1:0]       op_mode [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a[gi]    = req_a[gi*WIDTH +: WIDTH];
    assign op_b[gi]    = req_b[gi*WIDTH +: WIDTH];
    assign op_mode[gi] = req_mode[gi*2 +: 2];
  end

  // ---------------------------------------------------------------------------
  // Round-robin scan: candidates rr_ptr+1, rr_ptr+2, ... modulo NREQ, so the
  // last granted requester is always examined last.
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    return PW'(sum);
  endfunction

  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic          grant_ok;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr_reg;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && req_valid[wrap_idx(rr_ptr_reg, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_reg, k);
      end
    end
  end

  assign grant_ok = (state_reg == IDLE) && grant_found && !mul_busy;

  // The accept strobe must be combinational so the handshake completes in the
  // grant cycle. It is masked while rst is high: the FSM ignores that cycle,
  // so a visible strobe would make the requester believe it was served.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = !rst && grant_ok && (grant_idx == PW'(gi));
  end

  // ---------------------------------------------------------------------------
  // Watchdog counter (optional)
  // ---------------------------------------------------------------------------
`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_reg;
  logic          rsp_error_reg;
  assign rsp_error = rsp_error_reg;
`else
  assign rsp_error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= PW'(NREQ - 1);
      wait_first_reg <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_product    <= '0;
      mul_start      <= 1'b0;
      mul_a          <= '0;
      mul_b          <= '0;
      mul_mode       <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      rsp_error_reg  <= 1'b0;
`endif
    end else begin
      mul_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_ok) begin
            // Operands are captured here and held until the next grant, which
            // keeps them stable for the whole multiplication.
            mul_a      <= op_a[grant_idx];
            mul_b      <= op_b[grant_idx];
            mul_mode   <= op_mode[grant_idx];
            rsp_id     <= IDW'(grant_idx);
            rr_ptr_reg <= grant_idx;
            mul_start  <= 1'b1;
            state_reg  <= ISSUE;
          end
        end

        ISSUE: begin
          wait_first_reg <= 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
          wait_cnt_reg   <= '0;
`endif
          state_reg      <= WAIT;
        end

        WAIT: begin
          wait_first_reg <= 1'b0;
          // A done seen in the first WAIT cycle may belong to a previous
          // operation, so it does not qualify.
          if (!wait_first_reg && mul_done) begin
            rsp_product <= mul_product;
            rsp_valid   <= 1'b1;
            state_reg   <= RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
            rsp_error_reg <= 1'b0;
`endif
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th WAIT cycle without completion.
            rsp_product   <= '0;
            rsp_error_reg <= 1'b1;
            rsp_valid     <= 1'b1;
            state_reg     <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
